// File: rtl/alu_sweep_checker.sv
// Sweeps every {op, A, B} vector into a 4-bit ALU and checks each result against a golden model.
// Counts mismatches and logs the first failing vector, result and expected value.
module alu_sweep_checker #(
  parameter int SETTLE_CYCLES = 0,
  parameter bit STOP_ON_FAIL  = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic [3:0]  vec_a,
  output logic [3:0]  vec_b,
  output logic [1:0]  vec_op,
  output logic        vec_valid,
  input  logic [3:0]  dut_result,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [10:0] mismatch_count,
  output logic        fail_seen,
  output logic [9:0]  first_fail_vec,
  output logic [3:0]  first_fail_result,
  output logic [3:0]  first_fail_expected
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE_CYCLES);
  localparam logic [9:0]  LAST_IDX    = 10'd1023;
  localparam logic [10:0] COUNT_MAX   = 11'd1024;

  state_t      state_reg, state_next;
  logic [9:0]  idx_reg, idx_next;
  logic [3:0]  settle_reg, settle_next;
  logic [10:0] count_reg, count_next;
  logic        fail_seen_reg, fail_seen_next;
  logic [9:0]  ff_vec_reg, ff_vec_next;
  logic [3:0]  ff_res_reg, ff_res_next;
  logic [3:0]  ff_exp_reg, ff_exp_next;

  logic [3:0]  golden;
  logic        sample;
  logic        mismatch;

  // The index register is the vector itself, so vec_* are registered and hold in DONE/IDLE.
  assign vec_op = idx_reg[9:8];
  assign vec_a  = idx_reg[7:4];
  assign vec_b  = idx_reg[3:0];

  always_comb begin
    golden = 4'd0;
    case (vec_op)
      2'b00:   golden = vec_a + vec_b;
      2'b01:   golden = vec_a - vec_b;
      2'b10:   golden = vec_a & vec_b;
      default: golden = vec_a | vec_b;
    endcase
  end

  assign sample   = (state_reg == RUN) && (settle_reg == SETTLE_LAST);
  assign mismatch = sample && (dut_result != golden);

  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    settle_next    = settle_reg;
    count_next     = count_reg;
    fail_seen_next = fail_seen_reg;
    ff_vec_next    = ff_vec_reg;
    ff_res_next    = ff_res_reg;
    ff_exp_next    = ff_exp_reg;

    case (state_reg)
      IDLE, DONE: begin
        if (start && !abort) begin
          state_next     = RUN;
          idx_next       = 10'd0;
          settle_next    = 4'd0;
          count_next     = 11'd0;
          fail_seen_next = 1'b0;
          ff_vec_next    = 10'd0;
          ff_res_next    = 4'd0;
          ff_exp_next    = 4'd0;
        end
      end
      RUN: begin
        if (abort) begin
          // Partial results are deliberately kept so they can be inspected after a cancel.
          state_next  = IDLE;
          settle_next = 4'd0;
        end else if (sample) begin
          settle_next = 4'd0;
          if (mismatch) begin
            if (count_reg != COUNT_MAX) begin
              count_next = count_reg + 11'd1;
            end
            if (!fail_seen_reg) begin
              fail_seen_next = 1'b1;
              ff_vec_next    = idx_reg;
              ff_res_next    = dut_result;
              ff_exp_next    = golden;
            end
          end
          if ((idx_reg == LAST_IDX) || (STOP_ON_FAIL && mismatch && !fail_seen_reg)) begin
            state_next = DONE;
          end else begin
            idx_next = idx_reg + 10'd1;
          end
        end else begin
          settle_next = settle_reg + 4'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      idx_reg       <= 10'd0;
      settle_reg    <= 4'd0;
      count_reg     <= 11'd0;
      fail_seen_reg <= 1'b0;
      ff_vec_reg    <= 10'd0;
      ff_res_reg    <= 4'd0;
      ff_exp_reg    <= 4'd0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      settle_reg    <= settle_next;
      count_reg     <= count_next;
      fail_seen_reg <= fail_seen_next;
      ff_vec_reg    <= ff_vec_next;
      ff_res_reg    <= ff_res_next;
      ff_exp_reg    <= ff_exp_next;
    end
  end

  assign busy                = (state_reg == RUN);
  assign vec_valid           = busy;
  assign done                = (state_reg == DONE);
  assign pass                = done && (count_reg == 11'd0);
  assign mismatch_count      = count_reg;
  assign fail_seen           = fail_seen_reg;
  assign first_fail_vec      = ff_vec_reg;
  assign first_fail_result   = ff_res_reg;
  assign first_fail_expected = ff_exp_reg;

endmodule

// File: tb/tb_alu_sweep_checker.sv
// Drives three checker instances (plain, SETTLE_CYCLES=3, STOP_ON_FAIL=1) wired to a bench ALU
// whose per-vector fault table injects payloads; results are compared to a sweep reference model.
module tb_alu_sweep_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start_w [3];
  logic abort_w [3];
  logic [3:0]  vec_a_w [3];
  logic [3:0]  vec_b_w [3];
  logic [1:0]  vec_op_w [3];
  logic        valid_w [3];
  logic [3:0]  res_w [3];
  logic        busy_w [3];
  logic        done_w [3];
  logic        pass_w [3];
  logic [10:0] count_w [3];
  logic        fseen_w [3];
  logic [9:0]  ffvec_w [3];
  logic [3:0]  ffres_w [3];
  logic [3:0]  ffexp_w [3];

  logic [3:0] fault_mask [1024];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic [3:0] golden(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [3:0] r;
    case (op)
      2'd0:    r = a + b;
      2'd1:    r = a - b;
      2'd2:    r = a & b;
      default: r = a | b;
    endcase
    return r;
  endfunction

  // Bench ALU: golden function with an injectable XOR fault per vector.
  for (genvar gi = 0; gi < 3; gi++) begin : g_alu
    assign res_w[gi] = golden(vec_op_w[gi], vec_a_w[gi], vec_b_w[gi])
                     ^ fault_mask[{vec_op_w[gi], vec_a_w[gi], vec_b_w[gi]}];
  end

  alu_sweep_checker #(.SETTLE_CYCLES(0), .STOP_ON_FAIL(1'b0)) u_plain (
    .clk(clk), .rst_n(rst_n), .start(start_w[0]), .abort(abort_w[0]),
    .vec_a(vec_a_w[0]), .vec_b(vec_b_w[0]), .vec_op(vec_op_w[0]), .vec_valid(valid_w[0]),
    .dut_result(res_w[0]), .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
    .mismatch_count(count_w[0]), .fail_seen(fseen_w[0]), .first_fail_vec(ffvec_w[0]),
    .first_fail_result(ffres_w[0]), .first_fail_expected(ffexp_w[0]));

  alu_sweep_checker #(.SETTLE_CYCLES(3), .STOP_ON_FAIL(1'b0)) u_settle (
    .clk(clk), .rst_n(rst_n), .start(start_w[1]), .abort(abort_w[1]),
    .vec_a(vec_a_w[1]), .vec_b(vec_b_w[1]), .vec_op(vec_op_w[1]), .vec_valid(valid_w[1]),
    .dut_result(res_w[1]), .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
    .mismatch_count(count_w[1]), .fail_seen(fseen_w[1]), .first_fail_vec(ffvec_w[1]),
    .first_fail_result(ffres_w[1]), .first_fail_expected(ffexp_w[1]));

  alu_sweep_checker #(.SETTLE_CYCLES(0), .STOP_ON_FAIL(1'b1)) u_stop (
    .clk(clk), .rst_n(rst_n), .start(start_w[2]), .abort(abort_w[2]),
    .vec_a(vec_a_w[2]), .vec_b(vec_b_w[2]), .vec_op(vec_op_w[2]), .vec_valid(valid_w[2]),
    .dut_result(res_w[2]), .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]),
    .mismatch_count(count_w[2]), .fail_seen(fseen_w[2]), .first_fail_vec(ffvec_w[2]),
    .first_fail_result(ffres_w[2]), .first_fail_expected(ffexp_w[2]));

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mask();
    for (int i = 0; i < 1024; i++) fault_mask[i] = 4'd0;
  endtask

  // Reference: walk the vectors in sweep order and apply the mismatch/stop rules directly.
  task automatic ref_sweep(input bit stop, output int cnt, output int fvec, output int fres,
                           output int fexp, output int last);
    bit found = 0;
    logic [3:0] g, r;
    logic [9:0] v;
    cnt = 0; fvec = 0; fres = 0; fexp = 0; last = 1023;
    for (int i = 0; i < 1024; i++) begin
      v = 10'(i);
      g = golden(v[9:8], v[7:4], v[3:0]);
      r = g ^ fault_mask[i];
      if (r != g) begin
        cnt++;
        if (!found) begin
          found = 1; fvec = i; fres = int'(r); fexp = int'(g);
          if (stop) begin
            last = i;
            break;
          end
        end
      end
    end
  endtask

  task automatic sweep(input int k, input int settle, output int busy_cycles, output bit vec_ok);
    start_w[k] = 1'b1;
    @(negedge clk);
    start_w[k] = 1'b0;
    busy_cycles = 0;
    vec_ok = 1'b1;
    for (int n = 0; n < 6000 && !done_w[k]; n++) begin
      if (busy_w[k]) begin
        if (int'({vec_op_w[k], vec_a_w[k], vec_b_w[k]}) != busy_cycles / (settle + 1)) vec_ok = 1'b0;
        if (!valid_w[k]) vec_ok = 1'b0;
        busy_cycles++;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_check(input string tag, input int k, input int settle, input bit stop);
    int cnt, fvec, fres, fexp, last, bc;
    bit vok;
    ref_sweep(stop, cnt, fvec, fres, fexp, last);
    sweep(k, settle, bc, vok);
    chk({tag, ".done"}, int'(done_w[k]), 1);
    chk({tag, ".busy_cycles"}, bc, (last + 1) * (settle + 1));
    chk({tag, ".vec_seq"}, int'(vok), 1);
    chk({tag, ".pass"}, int'(pass_w[k]), (cnt == 0) ? 1 : 0);
    chk({tag, ".count"}, int'(count_w[k]), stop ? ((cnt > 0) ? 1 : 0) : cnt);
    chk({tag, ".fail_seen"}, int'(fseen_w[k]), (cnt > 0) ? 1 : 0);
    chk({tag, ".ff_vec"}, int'(ffvec_w[k]), fvec);
    chk({tag, ".ff_res"}, int'(ffres_w[k]), fres);
    chk({tag, ".ff_exp"}, int'(ffexp_w[k]), fexp);
    chk({tag, ".final_vec"}, int'({vec_op_w[k], vec_a_w[k], vec_b_w[k]}), last);
    chk({tag, ".valid_done"}, int'(valid_w[k]), 0);
    $display("sweep %s: busy_cycles=%0d count=%0d first_vec=0x%0h", tag, bc, count_w[k], ffvec_w[k]);
  endtask

  task automatic check_zero(input string tag, input int k);
    chk({tag, ".vec"}, int'({vec_op_w[k], vec_a_w[k], vec_b_w[k]}), 0);
    chk({tag, ".valid"}, int'(valid_w[k]), 0);
    chk({tag, ".busy"}, int'(busy_w[k]), 0);
    chk({tag, ".done"}, int'(done_w[k]), 0);
    chk({tag, ".pass"}, int'(pass_w[k]), 0);
    chk({tag, ".count"}, int'(count_w[k]), 0);
    chk({tag, ".fail_seen"}, int'(fseen_w[k]), 0);
    chk({tag, ".ff"}, int'({ffvec_w[k], ffres_w[k], ffexp_w[k]}), 0);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      start_w[k] = 1'b0;
      abort_w[k] = 1'b0;
    end
    clear_mask();

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) check_zero($sformatf("reset%0d", k), k);
    rst_n = 1'b1;
    @(negedge clk);

    // Clean ALU, one vector per cycle.
    run_check("clean", 0, 0, 1'b0);

    // Trojan: LSB flip whenever A=B=F, restarted from DONE.
    for (int op = 0; op < 4; op++) fault_mask[op * 256 + 255] = 4'h1;
    run_check("trojan", 0, 0, 1'b0);
    chk("trojan.count_const", int'(count_w[0]), 4);
    chk("trojan.ffvec_const", int'(ffvec_w[0]), 10'h0FF);
    chk("trojan.ffres_const", int'(ffres_w[0]), 4'hF);
    chk("trojan.ffexp_const", int'(ffexp_w[0]), 4'hE);

    run_check("trojan_stop", 2, 0, 1'b1);
    chk("trojan_stop.count_const", int'(count_w[2]), 1);
    chk("trojan_stop.vec_const", int'({vec_op_w[2], vec_a_w[2], vec_b_w[2]}), 10'h0FF);

    clear_mask();
    run_check("settle3", 1, 3, 1'b0);

    // Random fault payloads.
    for (int rnd = 0; rnd < 3; rnd++) begin
      clear_mask();
      for (int j = 0; j < int'($urandom_range(1, 20)); j++)
        fault_mask[$urandom_range(0, 1023)] = 4'($urandom_range(1, 15));
      run_check($sformatf("rand%0d", rnd), 0, 0, 1'b0);
      run_check($sformatf("rand%0d_stop", rnd), 2, 0, 1'b1);
    end
    run_check("rand_settle3", 1, 3, 1'b0);

    // Every vector faulty: count reaches its 1024 ceiling.
    for (int i = 0; i < 1024; i++) fault_mask[i] = 4'($urandom_range(1, 15));
    run_check("all_bad", 0, 0, 1'b0);

    // Abort together with start at the 100th RUN cycle.
    clear_mask();
    fault_mask[3] = 4'h4; fault_mask[10] = 4'h1; fault_mask[40] = 4'h8;
    start_w[0] = 1'b1;
    @(negedge clk);
    start_w[0] = 1'b0;
    repeat (99) @(negedge clk);
    chk("abort.busy_before", int'(busy_w[0]), 1);
    abort_w[0] = 1'b1;
    start_w[0] = 1'b1;
    @(negedge clk);
    abort_w[0] = 1'b0;
    start_w[0] = 1'b0;
    chk("abort.busy", int'(busy_w[0]), 0);
    chk("abort.done", int'(done_w[0]), 0);
    chk("abort.pass", int'(pass_w[0]), 0);
    chk("abort.valid", int'(valid_w[0]), 0);
    chk("abort.count_kept", int'(count_w[0]), 3);
    chk("abort.ffvec_kept", int'(ffvec_w[0]), 3);
    repeat (3) @(negedge clk);
    chk("abort.stays_idle", int'(busy_w[0]), 0);
    $display("abort: count=%0d first_vec=0x%0h", count_w[0], ffvec_w[0]);
    clear_mask();
    run_check("after_abort", 0, 0, 1'b0);

    // Asynchronous reset in the middle of a sweep.
    fault_mask[5] = 4'h2; fault_mask[300] = 4'h8; fault_mask[700] = 4'h3;
    start_w[0] = 1'b1;
    @(negedge clk);
    start_w[0] = 1'b0;
    repeat (499) @(negedge clk);
    chk("midreset.fail_seen_before", int'(fseen_w[0]), 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("midreset", 0);
    $display("reset asserted mid-sweep at t=%0t", $time);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_check("after_reset", 0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
